// File: rtl/uart_rx_frontend.sv
// 8N1 serial receive front end: synchronises rx, frames bytes, and emits data/error strobes.
// Optional UART_RX_MAJORITY_EN enables a 2-of-3 majority vote at every sample point.
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 900,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic       rx,
    input  logic       rx_fifo_full,
    output logic [7:0] rx_dout,
    output logic       rx_pres,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [2:0]             idx_q;
    logic [7:0]             shift_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   samp;

    // Synchroniser resets to the idle-line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rxs};
        end
    end

    assign samp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
    assign samp = rxs;
`endif

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_dout     <= 8'h00;
            rx_pres     <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rx_pres     <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rxs) begin
                        state_q <= START;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        if (samp) begin
                            state_q <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {samp, shift_q[7:1]};
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        busy    <= 1'b0;
                        // A held-low line re-enters START on the next edge, reporting a break per frame.
                        if (!samp) begin
                            frame_err <= 1'b1;
                        end else if (rx_fifo_full) begin
                            overrun_err <= 1'b1;
                        end else begin
                            rx_dout <= shift_q;
                            rx_pres <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend: good frames, back-to-back, framing/overrun errors,
// false start, mid-bit glitch and mid-frame reset.
module tb_uart_rx_frontend;

    logic       clk = 1'b0;
    logic       Rst;
    logic       rx;
    logic       rx_fifo_full;
    logic [7:0] rx_dout;
    logic       rx_pres;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_pres   = 0;
    int n_ferr   = 0;
    int n_ovr    = 0;
    int n_multi  = 0;
    logic [7:0] pres_data [16];
    int         pres_cyc  [16];

    uart_rx_frontend #(.CLKS_PER_BIT(900), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .Rst          (Rst),
        .rx           (rx),
        .rx_fifo_full (rx_fifo_full),
        .rx_dout      (rx_dout),
        .rx_pres      (rx_pres),
        .frame_err    (frame_err),
        .overrun_err  (overrun_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_pres) begin
            if (n_pres < 16) begin
                pres_data[n_pres] = rx_dout;
                pres_cyc[n_pres]  = cyc;
            end
            n_pres = n_pres + 1;
        end
        if (frame_err)   n_ferr = n_ferr + 1;
        if (overrun_err) n_ovr  = n_ovr + 1;
        if (int'(rx_pres) + int'(frame_err) + int'(overrun_err) > 1) n_multi = n_multi + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int gbit);
        drive_bit(1'b0, 900);
        for (int i = 0; i < 8; i++) begin
            if (i == gbit) begin
                drive_bit(b[i], 450);
                drive_bit(1'b0, 1);
                drive_bit(b[i], 449);
            end else begin
                drive_bit(b[i], 900);
            end
        end
        drive_bit(stop, 900);
    endtask

    initial begin
        int g;
        int bp;
        int bf;
        int bo;

        Rst = 1'b0;
        rx = 1'b1;
        rx_fifo_full = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_dout", 32'(rx_dout), 32'h00);
        check("rst_pres", 32'(rx_pres), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_ovr", 32'(overrun_err), 0);
        check("rst_busy", 32'(busy), 0);
        Rst = 1'b1;
        drive_bit(1'b1, 10);

        // Single good frame with exact strobe timing.
        bp = n_pres; bf = n_ferr; bo = n_ovr;
        g = cyc;
        send_frame(8'h55, 1'b1, -1);
        drive_bit(1'b1, 20);
        check("55_pres_cnt", 32'(n_pres - bp), 1);
        check("55_data", 32'(pres_data[bp]), 32'h55);
        check("55_cycle", 32'(pres_cyc[bp] - g), 8553);
        check("55_ferr", 32'(n_ferr - bf), 0);
        check("55_ovr", 32'(n_ovr - bo), 0);
        check("55_dout_hold", 32'(rx_dout), 32'h55);
        check("55_busy_idle", 32'(busy), 0);

        // Back-to-back frames.
        bp = n_pres;
        send_frame(8'hA3, 1'b1, -1);
        send_frame(8'h0F, 1'b1, -1);
        drive_bit(1'b1, 20);
        check("b2b_pres_cnt", 32'(n_pres - bp), 2);
        check("b2b_data0", 32'(pres_data[bp]), 32'hA3);
        check("b2b_data1", 32'(pres_data[bp + 1]), 32'h0F);
        check("b2b_spacing", 32'(pres_cyc[bp + 1] - pres_cyc[bp]), 9000);

        // Framing error: stop bit low.
        bp = n_pres; bf = n_ferr; bo = n_ovr;
        send_frame(8'h3C, 1'b0, -1);
        drive_bit(1'b1, 20);
        check("fe_ferr_cnt", 32'(n_ferr - bf), 1);
        check("fe_pres_cnt", 32'(n_pres - bp), 0);
        check("fe_ovr_cnt", 32'(n_ovr - bo), 0);
        check("fe_dout_hold", 32'(rx_dout), 32'h0F);

        // Overrun then recovery.
        rx_fifo_full = 1'b1;
        bp = n_pres; bf = n_ferr; bo = n_ovr;
        send_frame(8'h7E, 1'b1, -1);
        drive_bit(1'b1, 20);
        check("ov_ovr_cnt", 32'(n_ovr - bo), 1);
        check("ov_pres_cnt", 32'(n_pres - bp), 0);
        check("ov_ferr_cnt", 32'(n_ferr - bf), 0);
        check("ov_dout_hold", 32'(rx_dout), 32'h0F);
        rx_fifo_full = 1'b0;
        bp = n_pres;
        send_frame(8'h81, 1'b1, -1);
        drive_bit(1'b1, 20);
        check("ov_rec_cnt", 32'(n_pres - bp), 1);
        check("ov_rec_data", 32'(pres_data[bp]), 32'h81);

        // 100-cycle false start: busy drops exactly at E0+450.
        bp = n_pres; bf = n_ferr; bo = n_ovr;
        drive_bit(1'b0, 100);
        drive_bit(1'b1, 352);
        check("gl_busy_before", 32'(busy), 1);
        drive_bit(1'b1, 1);
        check("gl_busy_after", 32'(busy), 0);
        drive_bit(1'b1, 20);
        check("gl_no_strobe", 32'((n_pres - bp) + (n_ferr - bf) + (n_ovr - bo)), 0);

        // One-cycle low pulse at the bit-3 sample point of 8'hFF.
        bp = n_pres;
        send_frame(8'hFF, 1'b1, 3);
        drive_bit(1'b1, 20);
        check("mg_pres_cnt", 32'(n_pres - bp), 1);
`ifdef UART_RX_MAJORITY_EN
        check("mg_data", 32'(pres_data[bp]), 32'hFF);
`else
        check("mg_data", 32'(pres_data[bp]), 32'hF7);
`endif

        // Reset mid data bit 4, then a clean frame.
        bp = n_pres; bf = n_ferr; bo = n_ovr;
        drive_bit(1'b0, 900);
        for (int i = 0; i < 4; i++) drive_bit(i[0], 900);
        drive_bit(1'b1, 450);
        check("mr_busy_pre", 32'(busy), 1);
        Rst = 1'b0;
        #1;
        check("mr_dout", 32'(rx_dout), 32'h00);
        check("mr_busy", 32'(busy), 0);
        check("mr_pres", 32'(rx_pres), 0);
        drive_bit(1'b1, 20);
        check("mr_busy_hold", 32'(busy), 0);
        check("mr_dout_hold", 32'(rx_dout), 32'h00);
        Rst = 1'b1;
        drive_bit(1'b1, 20);
        check("mr_no_strobe", 32'((n_pres - bp) + (n_ferr - bf) + (n_ovr - bo)), 0);
        send_frame(8'h5A, 1'b1, -1);
        drive_bit(1'b1, 20);
        check("mr_pres_cnt", 32'(n_pres - bp), 1);
        check("mr_data", 32'(pres_data[bp]), 32'h5A);

        check("strobe_exclusive", 32'(n_multi), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
